// File: rtl/mac_sequencer.sv
// Operand FIFO + issue/accumulate sequencer wrapped around a 16x16 signed
// sequential multiplier; presents the accumulated dot product on a valid/ready port.
module mac_sequencer #(
   parameter int DEPTH = 4,
   parameter int ACC_W = 40
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    In_Valid,
   output logic                    In_Ready,
   input  logic signed [15:0]      In_A,
   input  logic signed [15:0]      In_B,
   input  logic                    In_Last,
   output logic                    Mul_Start,
   output logic signed [15:0]      Mul_Multiplicand,
   output logic signed [15:0]      Mul_Multiplier,
   input  logic signed [31:0]      Mul_Product,
   input  logic                    Mul_Done,
   output logic                    Out_Valid,
   input  logic                    Out_Ready,
   output logic signed [ACC_W-1:0] Out_Sum,
   output logic [7:0]              Out_Count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   USED_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ISSUE  = 3'd1;
   localparam logic [2:0] WAIT   = 3'd2;
   localparam logic [2:0] ACC    = 3'd3;
   localparam logic [2:0] OUTPUT = 3'd4;

   logic [2:0]              state;
   logic [32:0]             fifo_mem [DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW:0]             used;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic [32:0]             head;
   logic                    last_pend;
   logic                    done_prev;
   logic signed [31:0]      product;
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              count;

   // In_Ready derives only from the registered fill level, so a same-cycle pop never re-opens a full FIFO
   assign full     = (used == FULL_LVL);
   assign empty    = (used == '0);
   assign In_Ready = !full;
   assign push     = In_Valid && !full;
   assign pop      = (state == IDLE) && !empty;
   assign head     = fifo_mem[rd_ptr];

   always_ff @(posedge Clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {In_A, In_B, In_Last};
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   used <= used + USED_ONE;
            2'b01:   used <= used - USED_ONE;
            default: used <= used;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state            <= IDLE;
         Mul_Start        <= 1'b0;
         Mul_Multiplicand <= '0;
         Mul_Multiplier   <= '0;
         last_pend        <= 1'b0;
         done_prev        <= 1'b0;
         product          <= '0;
         acc              <= '0;
         count            <= '0;
         Out_Valid        <= 1'b0;
         Out_Sum          <= '0;
         Out_Count        <= '0;
      end else begin
         Mul_Start <= 1'b0;
         done_prev <= Mul_Done;
         case (state)
            IDLE: begin
               if (!empty) begin
                  Mul_Multiplicand <= head[32:17];
                  Mul_Multiplier   <= head[16:1];
                  last_pend        <= head[0];
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               Mul_Start <= 1'b1;
               state     <= WAIT;
            end
            WAIT: begin
               if (Mul_Done && !done_prev) begin
                  product <= Mul_Product;
                  state   <= ACC;
               end
            end
            ACC: begin
               acc   <= acc + ACC_W'(product);
               count <= (count == 8'd255) ? count : count + 8'd1;
               state <= last_pend ? OUTPUT : IDLE;
            end
            OUTPUT: begin
               // Result registers load on the first OUTPUT cycle; the handshake is honoured only once Out_Valid is up
               if (Out_Valid && Out_Ready) begin
                  Out_Valid <= 1'b0;
                  acc       <= '0;
                  count     <= '0;
                  state     <= IDLE;
               end else begin
                  Out_Valid <= 1'b1;
                  Out_Sum   <= acc;
                  Out_Count <= count;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural sequential multiplier
// (fixed latency, Done held two cycles) and hand-computed dot-product vectors.
module tb_mac_sequencer;

   localparam int DEPTH = 4;
   localparam int ACC_W = 40;

   logic                    Clock = 1'b0;
   logic                    Reset;
   logic                    In_Valid;
   logic                    In_Ready;
   logic signed [15:0]      In_A;
   logic signed [15:0]      In_B;
   logic                    In_Last;
   logic                    Mul_Start;
   logic signed [15:0]      Mul_Multiplicand;
   logic signed [15:0]      Mul_Multiplier;
   logic signed [31:0]      Mul_Product;
   logic                    Mul_Done;
   logic                    Out_Valid;
   logic                    Out_Ready;
   logic signed [ACC_W-1:0] Out_Sum;
   logic [7:0]              Out_Count;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   logic               model_done;
   logic signed [31:0] model_prod;
   logic               spur;
   int                 start_count;
   int                 last_start_cyc;
   int                 last_done_cyc;
   int                 last_push_edge;

   assign Mul_Done    = model_done | spur;
   assign Mul_Product = spur ? 32'sd1000 : model_prod;

   mac_sequencer #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
      .Clock            (Clock),
      .Reset            (Reset),
      .In_Valid         (In_Valid),
      .In_Ready         (In_Ready),
      .In_A             (In_A),
      .In_B             (In_B),
      .In_Last          (In_Last),
      .Mul_Start        (Mul_Start),
      .Mul_Multiplicand (Mul_Multiplicand),
      .Mul_Multiplier   (Mul_Multiplier),
      .Mul_Product      (Mul_Product),
      .Mul_Done         (Mul_Done),
      .Out_Valid        (Out_Valid),
      .Out_Ready        (Out_Ready),
      .Out_Sum          (Out_Sum),
      .Out_Count        (Out_Count)
   );

   always #5 Clock = ~Clock;

   initial forever begin
      @(posedge Clock);
      cyc++;
   end

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Multiplier model: Done rises 4 negedges after Start is seen, stays high 2 cycles.
   initial begin
      int               timer;
      int               hold;
      logic             start_prev;
      logic             valid_prev;
      logic signed [15:0] lat_a;
      logic signed [15:0] lat_b;
      timer = 0; hold = 0; start_prev = 1'b0; valid_prev = 1'b0;
      lat_a = '0; lat_b = '0;
      model_done = 1'b0; model_prod = '0;
      start_count = 0; last_start_cyc = 0; last_done_cyc = 0;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            model_done = 1'b0;
            timer      = 0;
            hold       = 0;
            start_prev = 1'b0;
            valid_prev = 1'b0;
         end else begin
            if (timer > 0) begin
               check("operand_a_stable", Mul_Multiplicand, lat_a);
               check("operand_b_stable", Mul_Multiplier, lat_b);
            end
            if (Mul_Start) begin
               check("start_single_cycle", start_prev, 0);
               start_count++;
               last_start_cyc = cyc;
               lat_a      = Mul_Multiplicand;
               lat_b      = Mul_Multiplier;
               timer      = 4;
               hold       = 0;
               model_done = 1'b0;
            end else if (timer > 0) begin
               timer--;
               if (timer == 0) begin
                  model_prod    = lat_a * lat_b;
                  model_done    = 1'b1;
                  hold          = 2;
                  last_done_cyc = cyc;
               end
            end else if (hold > 0) begin
               hold--;
               if (hold == 0) model_done = 1'b0;
            end
            if (Out_Valid && !valid_prev)
               check("out_valid_latency", cyc - last_done_cyc, 3);
            start_prev = Mul_Start;
            valid_prev = Out_Valid;
         end
      end
   end

   task automatic push(input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic last);
      int tries;
      tries    = 0;
      In_A     = a;
      In_B     = b;
      In_Last  = last;
      In_Valid = 1'b1;
      while (!In_Ready && tries < 200) begin
         @(negedge Clock);
         tries++;
      end
      check("push_accepted", In_Ready, 1);
      last_push_edge = cyc + 1;
      @(negedge Clock);
      In_Valid = 1'b0;
   endtask

   task automatic wait_valid();
      int tries;
      tries = 0;
      while (!Out_Valid && tries < 300) begin
         @(negedge Clock);
         tries++;
      end
      check("out_valid_timeout", Out_Valid, 1);
   endtask

   task automatic release_result();
      Out_Ready = 1'b1;
      @(negedge Clock);
      Out_Ready = 1'b0;
      check("out_valid_clears", Out_Valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  In_Ready, 1);
      check({tag, "_mul_start"}, Mul_Start, 0);
      check({tag, "_mul_a"},     Mul_Multiplicand, 0);
      check({tag, "_mul_b"},     Mul_Multiplier, 0);
      check({tag, "_out_valid"}, Out_Valid, 0);
      check({tag, "_out_sum"},   Out_Sum, 0);
      check({tag, "_out_count"}, Out_Count, 0);
   endtask

   typedef struct {
      logic signed [15:0]      a;
      logic signed [15:0]      b;
      logic                    last;
      logic signed [ACC_W-1:0] sum;
      logic [7:0]              cnt;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int start_base;
      int seen_valid;

      vecs[0] = '{16'sd12,  16'sd10,  1'b1, 40'sd120,   8'd1};
      vecs[1] = '{16'sd150, 16'sd0,   1'b0, 40'sd0,     8'd0};
      vecs[2] = '{16'sd150, 16'sd2,   1'b0, 40'sd0,     8'd0};
      vecs[3] = '{16'sd255, 16'sd250, 1'b1, 40'sd64050, 8'd3};
      vecs[4] = '{-16'sd3,  16'sd7,   1'b0, 40'sd0,     8'd0};
      vecs[5] = '{16'sd5,   -16'sd5,  1'b1, -40'sd46,   8'd2};

      Reset = 1'b1; In_Valid = 1'b0; In_A = '0; In_B = '0; In_Last = 1'b0;
      Out_Ready = 1'b0; spur = 1'b0; start_base = 0; last_push_edge = 0;
      repeat (2) @(negedge Clock);
      check_reset_outputs("reset");
      Reset = 1'b0;
      @(negedge Clock);

      // Table-driven dot products, each group pushed back-to-back
      for (int i = 0; i < 6; i++) begin
         if (i == 0) start_base = start_count;
         else if (vecs[i-1].last) start_base = start_count;
         push(vecs[i].a, vecs[i].b, vecs[i].last);
         if (vecs[i].last) begin
            wait_valid();
            check("dot_sum", Out_Sum, vecs[i].sum);
            check("dot_count", Out_Count, vecs[i].cnt);
            check("start_pulses", start_count - start_base, vecs[i].cnt);
            if (i == 0) check("issue_latency", last_start_cyc - last_push_edge, 2);
            if (i == 5) check("sign_upper_bits", Out_Sum[ACC_W-1:32], 8'hFF);
            repeat (3) begin
               @(negedge Clock);
               check("hold_valid", Out_Valid, 1);
               check("hold_sum", Out_Sum, vecs[i].sum);
            end
            release_result();
         end
      end

      // Backpressure: result stalled while the FIFO fills
      start_base = start_count;
      push(16'sd1, 16'sd2, 1'b1);
      push(16'sd3, 16'sd4, 1'b0);
      push(16'sd5, 16'sd6, 1'b0);
      push(16'sd7, 16'sd8, 1'b0);
      push(-16'sd9, 16'sd10, 1'b0);
      wait_valid();
      check("bp_first_sum", Out_Sum, 2);
      check("bp_first_count", Out_Count, 1);
      In_A = 16'sd11; In_B = 16'sd12; In_Last = 1'b1; In_Valid = 1'b1;
      repeat (4) begin
         @(negedge Clock);
         check("bp_full_ready", In_Ready, 0);
         check("bp_hold_valid", Out_Valid, 1);
         check("bp_hold_sum", Out_Sum, 2);
      end
      In_Valid = 1'b0;
      release_result();
      push(16'sd11, 16'sd12, 1'b1);
      wait_valid();
      check("bp_second_sum", Out_Sum, 140);
      check("bp_second_count", Out_Count, 5);
      check("bp_start_pulses", start_count - start_base, 6);
      release_result();

      // Reset while the multiplier is busy
      push(16'sd100, 16'sd100, 1'b1);
      begin
         int tries;
         tries = 0;
         while (!Mul_Start && tries < 50) begin
            @(negedge Clock);
            tries++;
         end
         check("wait_state_reached", Mul_Start, 1);
      end
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      check_reset_outputs("midreset");
      start_base = start_count;
      seen_valid = 0;
      repeat (15) begin
         @(negedge Clock);
         if (Out_Valid) seen_valid++;
      end
      check("midreset_no_valid", seen_valid, 0);
      check("midreset_fifo_empty", start_count - start_base, 0);
      push(16'sd2, 16'sd3, 1'b1);
      wait_valid();
      check("post_reset_sum", Out_Sum, 6);
      check("post_reset_count", Out_Count, 1);
      check("post_reset_latency", last_start_cyc - last_push_edge, 2);
      release_result();

      // Spurious Done edge while idle
      repeat (4) @(negedge Clock);
      start_base = start_count;
      spur = 1'b1;
      @(negedge Clock);
      spur = 1'b0;
      seen_valid = 0;
      repeat (10) begin
         @(negedge Clock);
         if (Out_Valid) seen_valid++;
      end
      check("spurious_no_valid", seen_valid, 0);
      check("spurious_no_start", start_count - start_base, 0);
      push(16'sd1, 16'sd1, 1'b1);
      wait_valid();
      check("spurious_acc_sum", Out_Sum, 1);
      check("spurious_acc_count", Out_Count, 1);
      release_result();

      repeat (3) @(negedge Clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Operand-feeding and result-accumulating stage wrapped around the 16x16 signed sequential multiplier. It buffers incoming operand pairs in a small FIFO and issues them one at a time to the multiplier over its Start/Done handshake. Each 32-bit signed product is accumulated into a wide register. When the pair tagged as last completes, the accumulated dot product is presented on a valid/ready output port.

## Interface
- DEPTH, 4: operand FIFO depth in entries; power of two, minimum 2.
- ACC_W, 40: accumulator and Out_Sum width; signed; minimum 32.

- Clock  in  1  single clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high; clears all state on a rising Clock edge where Reset=1.
- In_Valid  in  1  operand pair offered.
- In_Ready  out  1  FIFO can accept; equals !full.
- In_A  in  16  signed multiplicand.
- In_B  in  16  signed multiplier.
- In_Last  in  1  pair is the final term of the current dot product.
- Mul_Start  out  1  one-cycle start pulse to the multiplier.
- Mul_Multiplicand  out  16  operand A to the multiplier; registered.
- Mul_Multiplier  out  16  operand B to the multiplier; registered.
- Mul_Product  in  32  signed product from the multiplier.
- Mul_Done  in  1  multiplier completion flag; only its rising edge is meaningful.
- Out_Valid  out  1  dot-product result available.
- Out_Ready  in  1  consumer accepts the result.
- Out_Sum  out  ACC_W  signed accumulated sum.
- Out_Count  out  8  number of terms in Out_Sum; saturates at 255.

## Operation
- FIFO stores {A, B, Last}.
  - Push when In_Valid && In_Ready.
  - Pop only on entry to ISSUE.
  - A push and a pop in the same cycle are both honoured.
  - When the FIFO is full, In_Ready=0 even if a pop happens that cycle.
- FSM states: IDLE, ISSUE, WAIT, ACC, OUTPUT.
  - IDLE: FIFO non-empty -> ISSUE. Load the head into the operand registers and the pending-last flag, then pop.
  - ISSUE: Mul_Start=1 for this single cycle -> WAIT.
  - WAIT: on a Mul_Done rising edge (Done=1 now, 0 on the previous cycle), capture Mul_Product -> ACC.
  - ACC: acc <= acc + sign_extend(product); count <= min(count+1, 255).
    - Pending-last set -> OUTPUT.
    - Otherwise -> IDLE.
  - OUTPUT: Out_Valid=1, and Out_Sum/Out_Count hold the final acc/count.
    - On Out_Ready=1: acc <= 0, count <= 0 -> IDLE.
- Accumulation wraps modulo 2^ACC_W; there is no overflow flag.
- Mul_Multiplicand and Mul_Multiplier stay stable from ISSUE until the product is captured.
- A Mul_Done edge in any state other than WAIT is ignored.
- The FIFO continues accepting pairs during WAIT, ACC and OUTPUT.

## Timing
- Reset values:
  - In_Ready=1, Mul_Start=0, Mul_Multiplicand=0, Mul_Multiplier=0, Out_Valid=0, Out_Sum=0, Out_Count=0.
  - FIFO empty, acc=0, state IDLE, stored previous Mul_Done=0.
- Reset mid-operation, including WAIT or OUTPUT: everything above is restored on the next edge, and any in-flight product is discarded. The multiplier shares Reset.
- Latency: a pair pushed at edge t is issued with Mul_Start high during the cycle after edge t+2.
- Product captured at edge d (Done edge detected) -> ACC at d+1.
- The last term gives Out_Valid=1 from edge d+2.
- Back-to-back issue: the next Mul_Start comes no earlier than 2 cycles after ACC (IDLE, then ISSUE).
- All outputs are registered; none depends combinationally on inputs.
- Out_Valid, Out_Sum and Out_Count hold indefinitely while Out_Ready=0.

## Test plan
- Single term: (12, 10, Last=1) -> Out_Sum=120, Out_Count=1.
  - Exactly one Mul_Start pulse.
  - Out_Valid clears one cycle after Out_Ready.
- Dot product, pushed back-to-back: (150, 0), (150, 2), (255, 250, Last) -> Out_Sum=64050, Out_Count=3.
  - Three Mul_Start pulses.
  - Operands stable across each multiply.
- Signed: (-3, 7), (5, -5, Last) -> Out_Sum=-46, Out_Count=2.
  - Sign extension correct in the upper ACC_W bits.
- Backpressure and full FIFO: Out_Ready=0 and 6 pairs offered.
  - In_Ready drops after the FIFO fills with DEPTH entries.
  - Out_Valid and Out_Sum hold steady.
  - On release, remaining pairs drain and produce the correct second sum.
- Reset during WAIT after (100, 100):
  - All outputs return to reset values, the FIFO is empty, and no Out_Valid appears.
  - A subsequent (2, 3, Last) -> Out_Sum=6.
- Spurious Mul_Done pulse while IDLE -> ignored; acc unchanged and no Out_Valid.
